// File: rtl/frame_buffer_fifo_pkg.sv
// Shared definitions for the trace-frame buffer and its uploader.
// Holds the frame and statistics widths, sync markers and the read-side state encoding.
package frame_pkg;

  localparam int FRAME_W = 128;
  localparam int LOST_W  = 16;
  localparam int TOTAL_W = 32;

  // Markers the uploader places in its periodic sync frames.
  localparam logic [FRAME_W-1:0] SYNC_MARKER = 128'hA5A5_5A5A_F00D_CAFE_0000_0000_0000_0000;
  localparam logic [7:0]         SYNC_TAG    = 8'hA5;

  typedef enum logic [1:0] {
    RD_EMPTY = 2'b00,
    RD_FETCH = 2'b01,
    RD_VALID = 2'b10
  } rd_state_t;

  function automatic logic [LOST_W-1:0] sat_inc_lost(input logic [LOST_W-1:0] v);
    return (v == {LOST_W{1'b1}}) ? v : v + LOST_W'(1);
  endfunction

endpackage

// File: rtl/frame_buffer_fifo_ram.sv
// Simple dual-port frame store: one write port, one registered read port.
// No reset on storage so it maps onto block RAM.
module frame_ram
  import frame_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int DATA_W = FRAME_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Write port and one-cycle-latency read port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/frame_buffer_fifo.sv
// Elastic first-word-fall-through store of trace frames between assembler and uploader.
// Never stalls the writer: frames arriving when full are dropped and counted.
module frame_buffer_fifo
  import frame_pkg::*;
#(
  parameter int BUFFLENLOG2 = 9
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [FRAME_W-1:0]     FrameIn,
  input  logic                   FrameInValid,
  input  logic                   Flush,
  output logic [FRAME_W-1:0]     Frame,
  output logic                   FrameReady,
  input  logic                   FrameNext,
  output logic [BUFFLENLOG2-1:0] FramesCnt,
  output logic [LOST_W-1:0]      LostFrames,
  output logic [TOTAL_W-1:0]     TotalFrames,
  output logic                   Overflow
);

  localparam logic [BUFFLENLOG2-1:0] CAP    = {BUFFLENLOG2{1'b1}};
  localparam logic [BUFFLENLOG2-1:0] ZERO   = {BUFFLENLOG2{1'b0}};
  localparam logic [BUFFLENLOG2-1:0] ONE    = {{(BUFFLENLOG2-1){1'b0}}, 1'b1};

  rd_state_t               state;
  rd_state_t               state_next;
  logic [BUFFLENLOG2-1:0]  wr_ptr;
  logic [BUFFLENLOG2-1:0]  rd_ptr;
  logic [BUFFLENLOG2-1:0]  cnt;
  logic [BUFFLENLOG2-1:0]  ram_cnt;
  logic [FRAME_W-1:0]      ram_q;
  logic [FRAME_W-1:0]      frame_q;
  logic                    ready_q;
  logic [LOST_W-1:0]       lost_cnt;
  logic [TOTAL_W-1:0]      total_cnt;
  logic                    ovf_q;
  logic                    wr_accept;
  logic                    wr_drop;
  logic                    pop;
  logic                    rd_issue;
  logic                    load_head;

  // Fullness is judged on the registered count, so a same-cycle pop cannot make room.
  assign wr_accept = FrameInValid & ~Flush & (cnt != CAP);
  assign wr_drop   = FrameInValid & ~Flush & (cnt == CAP);
  assign pop       = FrameNext & ready_q & ~Flush;
  assign ram_cnt   = wr_ptr - rd_ptr;

  frame_ram #(
    .ADDR_W (BUFFLENLOG2),
    .DATA_W (FRAME_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_accept),
    .waddr (wr_ptr),
    .wdata (FrameIn),
    .re    (rd_issue),
    .raddr (rd_ptr),
    .rdata (ram_q)
  );

  // Read FSM next state and RAM fetch control.
  always_comb begin
    state_next = state;
    rd_issue   = 1'b0;
    load_head  = 1'b0;
    case (state)
      RD_EMPTY: begin
        if (ram_cnt != ZERO) begin
          rd_issue   = 1'b1;
          state_next = RD_FETCH;
        end else begin
          state_next = RD_EMPTY;
        end
      end
      RD_FETCH: begin
        load_head  = 1'b1;
        state_next = RD_VALID;
      end
      RD_VALID: begin
        if (pop) begin
          state_next = RD_EMPTY;
        end else begin
          state_next = RD_VALID;
        end
      end
      default: begin
        state_next = RD_EMPTY;
      end
    endcase
    if (Flush) begin
      state_next = RD_EMPTY;
      rd_issue   = 1'b0;
      load_head  = 1'b0;
    end else begin
      state_next = state_next;
    end
  end

  // State, pointers, occupancy, head register and statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RD_EMPTY;
      wr_ptr    <= ZERO;
      rd_ptr    <= ZERO;
      cnt       <= ZERO;
      frame_q   <= {FRAME_W{1'b0}};
      ready_q   <= 1'b0;
      lost_cnt  <= {LOST_W{1'b0}};
      total_cnt <= {TOTAL_W{1'b0}};
      ovf_q     <= 1'b0;
    end else begin
      state     <= state_next;
      ready_q   <= (state_next == RD_VALID);
      total_cnt <= total_cnt + {{(TOTAL_W-1){1'b0}}, FrameInValid};
      ovf_q     <= wr_drop;
      if (wr_drop) begin
        lost_cnt <= sat_inc_lost(lost_cnt);
      end
      if (load_head) begin
        frame_q <= ram_q;
      end
      if (Flush) begin
        rd_ptr <= wr_ptr;
        cnt    <= ZERO;
      end else begin
        if (wr_accept) begin
          wr_ptr <= wr_ptr + ONE;
        end
        if (rd_issue) begin
          rd_ptr <= rd_ptr + ONE;
        end
        case ({wr_accept, pop})
          2'b10:   cnt <= cnt + ONE;
          2'b01:   cnt <= cnt - ONE;
          default: cnt <= cnt;
        endcase
      end
    end
  end

  assign Frame       = frame_q;
  assign FrameReady  = ready_q;
  assign FramesCnt   = cnt;
  assign LostFrames  = lost_cnt;
  assign TotalFrames = total_cnt;
  assign Overflow    = ovf_q;

endmodule

// File: tb/tb_frame_buffer_fifo.sv
// Self-checking bench for frame_buffer_fifo with a 16-deep RAM (capacity 15).
// Inputs change on the falling edge; outputs are sampled on the following falling edge.
module tb_frame_buffer_fifo;
  import frame_pkg::*;

  localparam int B   = 4;
  localparam int CAP = 15;

  logic               clk;
  logic               rst;
  logic [FRAME_W-1:0] FrameIn;
  logic               FrameInValid;
  logic               Flush;
  logic [FRAME_W-1:0] Frame;
  logic               FrameReady;
  logic               FrameNext;
  logic [B-1:0]       FramesCnt;
  logic [LOST_W-1:0]  LostFrames;
  logic [TOTAL_W-1:0] TotalFrames;
  logic               Overflow;

  frame_buffer_fifo #(.BUFFLENLOG2(B)) dut (
    .clk          (clk),
    .rst          (rst),
    .FrameIn      (FrameIn),
    .FrameInValid (FrameInValid),
    .Flush        (Flush),
    .Frame        (Frame),
    .FrameReady   (FrameReady),
    .FrameNext    (FrameNext),
    .FramesCnt    (FramesCnt),
    .LostFrames   (LostFrames),
    .TotalFrames  (TotalFrames),
    .Overflow     (Overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic               v;
    logic [FRAME_W-1:0] d;
    logic               n;
    logic               exp_ready;
    int                 exp_cnt;
  } vec_t;

  vec_t               tbl [12];
  logic [FRAME_W-1:0] sb [$];
  int                 m_cnt;
  logic [LOST_W-1:0]  m_lost;
  logic [TOTAL_W-1:0] m_total;
  int                 errors;
  int                 checks;

  function automatic logic [FRAME_W-1:0] fv(input int i);
    logic [31:0] x;
    x = 32'(i);
    return {32'hC0DE_0000 + x, ~x, x * 32'd7, 32'hF00D_0000 ^ x};
  endfunction

  task automatic chk(input string name, input logic [FRAME_W-1:0] act, input logic [FRAME_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; FrameInValid = 1'b0; FrameNext = 1'b0; Flush = 1'b0;
    FrameIn = {FRAME_W{1'b0}};
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst = 1'b0;
    sb.delete(); m_cnt = 0; m_lost = 16'h0000; m_total = 32'h0000_0000;
    chk("rst_frame", Frame, {FRAME_W{1'b0}});
    chk("rst_ready", {127'd0, FrameReady}, 128'd0);
    chk("rst_cnt", {124'd0, FramesCnt}, 128'd0);
    chk("rst_lost", {112'd0, LostFrames}, 128'd0);
    chk("rst_total", {96'd0, TotalFrames}, 128'd0);
    chk("rst_ovf", {127'd0, Overflow}, 128'd0);
  endtask

  // One clock: drive at the falling edge, update the model, check after the rising edge.
  task automatic step(input logic v, input logic [FRAME_W-1:0] d, input logic n, input logic f);
    logic               exp_ovf;
    logic               w_ok;
    logic [FRAME_W-1:0] head;
    FrameInValid = v; FrameIn = d; FrameNext = n; Flush = f;
    exp_ovf = 1'b0;
    if (v) m_total = m_total + 32'd1;
    if (f) begin
      sb.delete();
      m_cnt = 0;
    end else begin
      w_ok = v && (m_cnt < CAP);
      if (v && !w_ok) begin
        exp_ovf = 1'b1;
        if (m_lost != 16'hFFFF) m_lost = m_lost + 16'd1;
      end
      if (n && sb.size() > 0) begin
        chk("ready_at_pop", {127'd0, FrameReady}, 128'd1);
        head = sb.pop_front();
        chk("head_frame", Frame, head);
        m_cnt--;
      end
      if (w_ok) begin
        sb.push_back(d);
        m_cnt++;
      end
    end
    @(posedge clk); @(negedge clk);
    FrameInValid = 1'b0; FrameNext = 1'b0; Flush = 1'b0;
    chk("frames_cnt", {124'd0, FramesCnt}, 128'(m_cnt));
    chk("lost", {112'd0, LostFrames}, {112'd0, m_lost});
    chk("total", {96'd0, TotalFrames}, {96'd0, m_total});
    chk("overflow", {127'd0, Overflow}, {127'd0, exp_ovf});
  endtask

  initial begin
    logic [FRAME_W-1:0] a;
    int i;
    errors = 0; checks = 0;
    a = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
    tbl[0]  = '{1'b1, a,      1'b0, 1'b0, 1};
    tbl[1]  = '{1'b0, 128'd0, 1'b0, 1'b0, 1};
    tbl[2]  = '{1'b0, 128'd0, 1'b0, 1'b1, 1};
    tbl[3]  = '{1'b0, 128'd0, 1'b1, 1'b0, 0};
    tbl[4]  = '{1'b0, 128'd0, 1'b0, 1'b0, 0};
    tbl[5]  = '{1'b1, fv(1),  1'b0, 1'b0, 1};
    tbl[6]  = '{1'b1, fv(2),  1'b0, 1'b0, 2};
    tbl[7]  = '{1'b0, 128'd0, 1'b0, 1'b1, 2};
    tbl[8]  = '{1'b0, 128'd0, 1'b1, 1'b0, 1};
    tbl[9]  = '{1'b0, 128'd0, 1'b0, 1'b0, 1};
    tbl[10] = '{1'b0, 128'd0, 1'b0, 1'b1, 1};
    tbl[11] = '{1'b0, 128'd0, 1'b1, 1'b0, 0};

    do_reset();
    for (int k = 0; k < 12; k++) begin
      step(tbl[k].v, tbl[k].d, tbl[k].n, 1'b0);
      chk($sformatf("tbl%0d_ready", k), {127'd0, FrameReady}, {127'd0, tbl[k].exp_ready});
      chk($sformatf("tbl%0d_cnt", k), {124'd0, FramesCnt}, 128'(tbl[k].exp_cnt));
    end

    // Fill to capacity; the sixteenth write is dropped.
    do_reset();
    for (int k = 0; k < 16; k++) step(1'b1, fv(100 + k), 1'b0, 1'b0);
    chk("ovf_pulse", {127'd0, Overflow}, 128'd1);
    chk("ovf_lost", {112'd0, LostFrames}, 128'd1);
    chk("ovf_total", {96'd0, TotalFrames}, 128'd16);
    step(1'b0, 128'd0, 1'b0, 1'b0);
    // Pop while full does not rescue the write; at 14 both are accepted.
    step(1'b1, fv(200), 1'b1, 1'b0);
    chk("full_pop_cnt", {124'd0, FramesCnt}, 128'd14);
    chk("full_pop_lost", {112'd0, LostFrames}, 128'd2);
    step(1'b0, 128'd0, 1'b0, 1'b0);
    step(1'b0, 128'd0, 1'b0, 1'b0);
    step(1'b1, fv(201), 1'b1, 1'b0);
    chk("wr_pop_cnt", {124'd0, FramesCnt}, 128'd14);

    // Streaming across pointer wrap with a pop every third cycle.
    do_reset();
    i = 0;
    while ((i < 40 || sb.size() > 0) && i < 400) begin
      step(i < 40, fv(300 + i), (i >= 3) && (i % 3 == 0) && (sb.size() > 0), 1'b0);
      i++;
    end
    chk("stream_drained", 128'(sb.size()), 128'd0);
    chk("stream_cnt", {124'd0, FramesCnt}, 128'd0);

    // Lost-frame counter saturates while the total keeps counting.
    do_reset();
    for (int k = 0; k < 15; k++) step(1'b1, fv(500 + k), 1'b0, 1'b0);
    force dut.lost_cnt = 16'hFFFE;
    #1;
    release dut.lost_cnt;
    m_lost = 16'hFFFE;
    for (int k = 0; k < 3; k++) step(1'b1, fv(600 + k), 1'b0, 1'b0);
    chk("sat_lost", {112'd0, LostFrames}, 128'h0000_FFFF);
    chk("sat_total", {96'd0, TotalFrames}, 128'd18);

    // Flush with simultaneous write and pop, then a fresh write.
    do_reset();
    for (int k = 0; k < 5; k++) step(1'b1, fv(700 + k), 1'b0, 1'b0);
    chk("pre_flush_ready", {127'd0, FrameReady}, 128'd1);
    step(1'b1, fv(800), 1'b1, 1'b1);
    chk("flush_ready", {127'd0, FrameReady}, 128'd0);
    chk("flush_cnt", {124'd0, FramesCnt}, 128'd0);
    chk("flush_total", {96'd0, TotalFrames}, 128'd6);
    chk("flush_lost", {112'd0, LostFrames}, 128'd0);
    step(1'b1, fv(900), 1'b0, 1'b0);
    step(1'b0, 128'd0, 1'b0, 1'b0);
    chk("post_flush_ready1", {127'd0, FrameReady}, 128'd0);
    step(1'b0, 128'd0, 1'b0, 1'b0);
    chk("post_flush_ready2", {127'd0, FrameReady}, 128'd1);
    step(1'b0, 128'd0, 1'b1, 1'b0);
    chk("post_flush_empty", {124'd0, FramesCnt}, 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/frame_buffer_fifo.md
Name: frame_buffer_fifo

Overview:
Elastic store of 128-bit trace frames between the frame assembler (write side) and the frame-to-serial uploader (read side).
- Accepts one frame per cycle.
- Presents the head frame first-word-fall-through, with FrameReady/FrameNext pop semantics.
- Reports occupancy, plus lost-frame and total-frame statistics that the uploader embeds in its periodic sync frames.
- Drops frames on overflow and never stalls the writer.

Parameters:
- BUFFLENLOG2, 9: log2 of RAM depth. Usable capacity is CAP = 2^BUFFLENLOG2 - 1 frames.
- FRAME_W, 128: frame width in bits. Fixed by the shared package; not intended to be overridden.

Ports:
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- FrameIn  in  128  frame from the assembler.
- FrameInValid  in  1  one-cycle strobe: FrameIn is valid this cycle.
- Flush  in  1  synchronous discard of all stored frames; statistics are kept.
- Frame  out  128  head frame; valid only while FrameReady=1.
- FrameReady  out  1  head frame is available.
- FrameNext  in  1  pop request; ignored when FrameReady=0.
- FramesCnt  out  BUFFLENLOG2  frames held, including the head/in-flight frame.
- LostFrames  out  16  frames dropped on overflow; saturates.
- TotalFrames  out  32  FrameInValid strobes seen, including dropped ones; wraps.
- Overflow  out  1  one-cycle pulse when a frame is dropped.

Behaviour:
- Reset (synchronous, rst sampled high at an edge):
  - Frame=0, FrameReady=0, FramesCnt=0, LostFrames=0, TotalFrames=0, Overflow=0.
  - Pointers cleared; read FSM goes to RD_EMPTY.
  - Reset mid-transfer discards all content. RAM contents are don't-care.
- Write path:
  - On each edge with FrameInValid=1, TotalFrames increments (mod 2^32).
  - If FramesCnt < CAP, evaluated on the registered value before this edge, the frame is written at wrPtr and wrPtr increments mod 2^BUFFLENLOG2.
  - Otherwise the frame is dropped: Overflow=1 for one cycle, and LostFrames increments, saturating at 16'hFFFF.
  - A pop in the same cycle does not rescue a write when full.
- Read FSM (RAM read is synchronous, 1-cycle latency). ramCnt = entries in RAM not yet fetched.
  - RD_EMPTY: if ramCnt>0, issue read at rdPtr, increment rdPtr, go to RD_FETCH.
  - RD_FETCH: load Frame from RAM, set FrameReady=1, go to RD_VALID.
  - RD_VALID: on FrameNext=1, set FrameReady=0 and go to RD_EMPTY. Frame holds its value, but it is don't-care once FrameReady=0.
- Latencies:
  - Write into an empty FIFO at edge k: FrameReady=1 after edge k+2.
  - Pop at edge p with more frames stored: next FrameReady=1 after edge p+2.
  - Write-to-read bypass is not permitted.
- FramesCnt:
  - +1 on an accepted write, -1 on an accepted pop. Both at once leaves it unchanged.
  - It is registered and updated at the same edge as the event.
  - Never exceeds CAP and never underflows.
- Flush (edge with Flush=1):
  - Pointers equalised, FramesCnt=0, FrameReady=0, FSM to RD_EMPTY.
  - A FrameInValid in the same cycle is counted in TotalFrames but discarded, and is not counted as lost.
  - A FrameNext in the same cycle is ignored.
- Priority: rst > Flush > normal operation.
- Frame is a registered output only; there is no combinational path from FrameNext to Frame or FrameReady.

Decomposition:
- Shared package frame_pkg:
  - FRAME_W=128.
  - Statistics widths: LOST_W=16, TOTAL_W=32.
  - Sync marker constants used by the uploader.
  - Read FSM state encoding: RD_EMPTY, RD_FETCH, RD_VALID.
- One sub-module, frame_ram: simple dual-port RAM, depth 2^BUFFLENLOG2 x FRAME_W, one write port, one synchronous read port. Coded for block-RAM inference; no reset on the storage.

Test Plan:
- Reset, then one write of 128'h0123...CDEF at edge k -> FrameReady rises after edge k+2, Frame equals the written value, FramesCnt=1. Pop -> FrameReady=0 and FramesCnt=0 after the pop edge.
- BUFFLENLOG2=4: write 16 frames back-to-back with no pops -> first 15 accepted, FramesCnt=15. 16th produces Overflow pulse, LostFrames=1, TotalFrames=16.
- Fill to 15, then write and pop in the same cycle -> write dropped (LostFrames+1), FramesCnt=14. Next write and pop together at FramesCnt=14 -> both accepted, FramesCnt stays 14.
- Write 40 frames with pops interleaved every 3 cycles -> output sequence identical to input order across pointer wrap (depth 16); no loss while FramesCnt<15.
- Force LostFrames to 16'hFFFE, cause 3 drops -> LostFrames holds 16'hFFFF; TotalFrames keeps counting.
- With 5 frames stored and FrameReady=1, assert Flush together with FrameInValid and FrameNext -> next cycle FramesCnt=0, FrameReady=0, TotalFrames+1, LostFrames unchanged. Subsequent write is delivered 2 cycles later.
